noc_inject_arb: RTL

//  Round-robin injection arbiter: K local traffic sources share one client injection port (c_o/c_o_v/c_o_bp).

---
 rtl/noc_inject_arb_pkg.sv | 15 +
 rtl/noc_inject_arb_fifo.sv | 52 +++++
 rtl/noc_inject_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/noc_inject_arb_pkg.sv
// Shared types and helpers for the NoC injection arbiter.
// Packet layout: {valid bit, address [A_W+D_W-1:D_W], data [D_W-1:0]}.
package noc_inject_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // Round-robin successor of a requester index, wrapping K-1 back to 0.
  function automatic int rr_next(input int idx, input int k);
    return (idx + 1 >= k) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_inject_arb_fifo.sv
// Per-requester packet FIFO; pointers wrap naturally, count is one bit wider than the pointers.
module noc_inject_arb_fifo #(
  parameter int P_W   = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [P_W-1:0]           din,
  output logic [P_W-1:0]           head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [P_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the write even when a pop happens in the same cycle.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_inject_arb.sv
// Round-robin injection arbiter: K local sources share one registered client injection port,
// with optional burst holding of the grant and router backpressure on the output stage.
module noc_inject_arb
  import noc_inject_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N) + 1,
  parameter int K     = 4,
  parameter int DEPTH = 4,
  parameter int BURST = 1,
  localparam int P_W  = A_W + D_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [K*P_W-1:0]   req_d,
  input  logic [K-1:0]       req_v,
  output logic [K-1:0]       req_bp,
  output logic [P_W-1:0]     c_o,
  output logic               c_o_v,
  input  logic               c_o_bp,
  output logic [K-1:0]       grant,
  output logic               idle
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RR_W  = $clog2(K);
  localparam int BC_W  = $clog2(BURST + 1);

  logic [P_W-1:0]   fifo_head  [K];
  logic [CNT_W-1:0] fifo_count [K];
  logic [K-1:0]     fifo_full;
  logic [K-1:0]     fifo_empty;
  logic [K-1:0]     push;
  logic [K-1:0]     pop;

  arb_state_t       state, state_n;
  logic [RR_W-1:0]  rr_ptr, rr_n;
  logic [RR_W-1:0]  owner, owner_n;
  logic [BC_W-1:0]  burst_cnt, bc_n;
  logic [RR_W-1:0]  sel_idx;
  logic             sel_v;
  logic             more;
  logic             ld;
  logic             c_o_v_n;

  assign ld     = ce & ~c_o_bp;
  assign req_bp = fifo_full;
  assign push   = req_v & ~fifo_full & {K{ce}};
  assign pop    = (ld && sel_v) ? (K'(1) << sel_idx) : '0;

  for (genvar g = 0; g < K; g++) begin : g_fifo
    noc_inject_arb_fifo #(.P_W(P_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (req_d[g*P_W +: P_W]),
      .head  (fifo_head[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .count (fifo_count[g])
    );
  end

  // In HOLD only the owner may be selected; in ARB the scan starts at rr_ptr.
  always_comb begin
    int cand;
    cand    = 0;
    sel_v   = 1'b0;
    sel_idx = '0;
    if (state == ST_HOLD) begin
      if (!fifo_empty[owner]) begin
        sel_v   = 1'b1;
        sel_idx = owner;
      end
    end else begin
      for (int off = 0; off < K; off++) begin
        cand = int'(rr_ptr) + off;
        if (cand >= K) cand = cand - K;
        if (!sel_v && !fifo_empty[cand]) begin
          sel_v   = 1'b1;
          sel_idx = RR_W'(cand);
        end
      end
    end
  end

  assign more = (fifo_count[sel_idx] > CNT_W'(1));

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    bc_n    = burst_cnt;
    if (ld) begin
      if (state == ST_ARB) begin
        if (sel_v) begin
          bc_n = BC_W'(1);
          if (BURST > 1 && more) begin
            state_n = ST_HOLD;
            owner_n = sel_idx;
          end else begin
            rr_n = RR_W'(rr_next(int'(sel_idx), K));
          end
        end
      end else if (!sel_v) begin
        state_n = ST_ARB;
        rr_n    = RR_W'(rr_next(int'(owner), K));
      end else begin
        bc_n = burst_cnt + 1'b1;
        if (int'(burst_cnt) + 1 >= BURST || !more) begin
          state_n = ST_ARB;
          rr_n    = RR_W'(rr_next(int'(owner), K));
        end
      end
    end
  end

  assign c_o_v_n = ld ? sel_v : c_o_v;

  // Under backpressure the output stage, including the grant of the held packet, is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      c_o       <= '0;
      c_o_v     <= 1'b0;
      grant     <= '0;
      idle      <= 1'b1;
    end else if (ce) begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      owner     <= owner_n;
      burst_cnt <= bc_n;
      idle      <= (&fifo_empty) & ~c_o_v_n;
      if (ld) begin
        c_o_v <= sel_v;
        grant <= pop;
        if (sel_v) c_o <= fifo_head[sel_idx];
      end
    end
  end

endmodule
